// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO word packer.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
// Contents: state_t (FILL/HOLD), default parameter values, lane_in_mask().
package fifo_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int unsigned DEF_DATA_WIDTH   = 8;
  localparam int unsigned DEF_PACK_RATIO   = 4;
  localparam int unsigned DEF_IDLE_TIMEOUT = 16;

  // Bit 'lane' of the keep mask for a word holding 'count' bytes.
  // Lanes 0..count-1 are valid.
  function automatic logic lane_in_mask(input int unsigned lane, input int unsigned count);
    return lane < count;
  endfunction

endpackage

// File: rtl/idle_timer.sv
// Idle counter: counts enabled cycles and flags when TIMEOUT is reached.
// Latency: expired rises the cycle after the TIMEOUT-th enabled cycle.
// Backpressure: none; saturates at TIMEOUT until cleared.
// Ports: clk, reset (sync, active-high), clear, enable, expired.
module idle_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned IW = $clog2(TIMEOUT + 1);

  logic [IW-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == IW'(TIMEOUT));

  // Holding at TIMEOUT keeps the counter from ever wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expired) begin
      cnt_d = cnt_q + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_word_packer.sv
// Packs PACK_RATIO FIFO bytes into one word; emits partial words on flush or idle timeout.
// Latency: word valid one cycle after the last lane fills (read-to-data is one cycle).
// Backpressure: out_ready low holds the word stable in HOLD and stops all FIFO reads.
// Ports: clk, reset; fifo_rd_en/fifo_rd_data/fifo_rd_val (upstream FIFO);
//        flush; out_data/out_keep/out_valid/out_ready (downstream word).
module fifo_word_packer
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int unsigned PACK_RATIO   = DEF_PACK_RATIO,
  parameter int unsigned IDLE_TIMEOUT = DEF_IDLE_TIMEOUT
) (
  input  logic                             clk,
  input  logic                             reset,
  output logic                             fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]            fifo_rd_data,
  input  logic                             fifo_rd_val,
  input  logic                             flush,
  output logic [DATA_WIDTH*PACK_RATIO-1:0] out_data,
  output logic [PACK_RATIO-1:0]            out_keep,
  output logic                             out_valid,
  input  logic                             out_ready
);

  localparam int unsigned CW = $clog2(PACK_RATIO + 1);
  localparam int unsigned OW = DATA_WIDTH * PACK_RATIO;

  state_t                state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  pending_q;
  logic                  emit_q, emit_d;
  logic [OW-1:0]         data_q, data_d;
  logic [PACK_RATIO-1:0] keep_q, keep_d;

  logic [CW:0] occupancy;
  logic        accept;
  logic        flush_hit;
  logic        expired;
  logic        emit_active;
  logic        go_hold;
  logic        timer_clear;
  logic        timer_en;

  // Bytes held plus the read still in flight; reads stop once this covers a word.
  assign occupancy = {1'b0, count_q} + (CW+1)'(pending_q);

  // A response only counts in the cycle after a read request.
  assign accept    = (state_q == FILL) && pending_q && fifo_rd_val;

  assign flush_hit = (state_q == FILL) && flush && ((count_q != '0) || pending_q);

  // Emission in progress: reads stop, any in-flight response is absorbed first.
  assign emit_active = (state_q == FILL) && (emit_q || expired || flush_hit);

  // A partial emission with no bytes collected simply drops back to filling.
  assign go_hold = (state_q == FILL) &&
                   ((count_q == CW'(PACK_RATIO)) ||
                    (emit_active && !pending_q && (count_q != '0)));

  assign timer_clear = accept || (state_q == HOLD);
  assign timer_en    = (state_q == FILL) && (count_q != '0) && !accept && !expired;

  idle_timer #(
    .TIMEOUT(IDLE_TIMEOUT)
  ) u_idle_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (timer_en),
    .expired(expired)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FILL;
      count_q   <= '0;
      pending_q <= 1'b0;
      emit_q    <= 1'b0;
      data_q    <= '0;
      keep_q    <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      pending_q <= fifo_rd_en;
      emit_q    <= emit_d;
      data_q    <= data_d;
      keep_q    <= keep_d;
    end
  end

  // Next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (go_hold)   state_d = HOLD;
      HOLD:    if (out_ready) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // Datapath next values.
  always_comb begin
    count_d = count_q;
    data_d  = data_q;
    keep_d  = keep_q;
    emit_d  = emit_q;
    if (state_q == FILL) begin
      if (accept) begin
        for (int unsigned i = 0; i < PACK_RATIO; i++) begin
          if (count_q == CW'(i)) begin
            data_d[i*DATA_WIDTH +: DATA_WIDTH] = fifo_rd_data;
          end
        end
        count_d = count_q + CW'(1);
      end
      if (go_hold) begin
        emit_d = 1'b0;
        for (int unsigned i = 0; i < PACK_RATIO; i++) begin
          keep_d[i] = lane_in_mask(i, 32'(count_q));
        end
      end else begin
        // Remember the emission only while a response is still to be absorbed.
        emit_d = emit_active && pending_q;
      end
    end else if (out_ready) begin
      // Clearing data here keeps lanes outside out_keep at zero for the next word.
      count_d = '0;
      data_d  = '0;
      keep_d  = '0;
      emit_d  = 1'b0;
    end
  end

  // Outputs.
  always_comb begin
    fifo_rd_en = 1'b0;
    if (!reset && (state_q == FILL) && !emit_active &&
        (occupancy < (CW+1)'(PACK_RATIO))) begin
      fifo_rd_en = 1'b1;
    end
    out_valid = (state_q == HOLD);
    out_data  = data_q;
    out_keep  = keep_q;
  end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed testbench for fifo_word_packer with a one-cycle-latency FIFO model.
// Latency: not applicable.
// Backpressure: exercised through out_ready stalls.
module tb_fifo_word_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fifo_rd_en;
  logic [7:0]  fifo_rd_data = 8'h00;
  logic        fifo_rd_val = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_valid;
  logic        out_ready = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] fifo_q[$];

  always #5 clk = ~clk;

  fifo_word_packer dut (
    .clk         (clk),
    .reset       (reset),
    .fifo_rd_en  (fifo_rd_en),
    .fifo_rd_data(fifo_rd_data),
    .fifo_rd_val (fifo_rd_val),
    .flush       (flush),
    .out_data    (out_data),
    .out_keep    (out_keep),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  // Upstream FIFO: answers a read one cycle later; between reads it drives
  // junk with val=1, which the packer must ignore.
  initial begin
    logic en;
    forever begin
      @(negedge clk);
      en = fifo_rd_en;
      @(posedge clk);
      #1;
      if (en) begin
        if (fifo_q.size() > 0) begin
          fifo_rd_val  = 1'b1;
          fifo_rd_data = fifo_q.pop_front();
        end else begin
          fifo_rd_val  = 1'b0;
          fifo_rd_data = 8'h00;
        end
      end else begin
        fifo_rd_val  = 1'b1;
        fifo_rd_data = 8'hEE;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reset, load the FIFO while in reset, release. Returns at the start of cycle 0.
  task automatic do_reset(input int n, input logic [63:0] bytes);
    @(posedge clk); #1;
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    fifo_q.delete();
    for (int i = 0; i < n; i++) fifo_q.push_back(bytes[8*i +: 8]);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic wait_valid(input int max_cycles, input string name);
    int k = 0;
    while (out_valid !== 1'b1 && k < max_cycles) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: out_valid never rose within %0d cycles", name, max_cycles);
    end
  endtask

  task automatic accept_word();
    @(posedge clk); #1; out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL rst_rd_en: got %b want 0", fifo_rd_en); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    n_checks++; if (out_keep !== 4'h0) begin n_fail++; $display("FAIL rst_keep: got %h want 0", out_keep); end
    n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL rst_data: got %h want 0", out_data); end
  endtask

  task automatic test_full_word();
    do_reset(8, 64'h88776655_44332211);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL full_early_valid: cycle %0d got %b want 0", c, out_valid); end
    end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL full_valid_c6: got %b want 1", out_valid); end
    n_checks++; if (out_data !== 32'h44332211) begin n_fail++; $display("FAIL full_data: got %h want 44332211", out_data); end
    n_checks++; if (out_keep !== 4'hF) begin n_fail++; $display("FAIL full_keep: got %h want f", out_keep); end
  endtask

  task automatic test_hold_stall();
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h44332211 || out_keep !== 4'hF || fifo_rd_en !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_stable: cycle %0d got v=%b d=%h k=%h rd=%b want v=1 d=44332211 k=f rd=0",
                 c, out_valid, out_data, out_keep, fifo_rd_en);
      end
    end
    @(posedge clk); #1; out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1 || out_data !== 32'h44332211) begin n_fail++; $display("FAIL stall_accept: got v=%b d=%h want v=1 d=44332211", out_valid, out_data); end
    @(posedge clk); #1; out_ready = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fill_valid: got %b want 0", out_valid); end
    n_checks++; if (fifo_rd_en !== 1'b1) begin n_fail++; $display("FAIL fill_rd_en: got %b want 1", fifo_rd_en); end
    n_checks++; if (out_keep !== 4'h0) begin n_fail++; $display("FAIL fill_keep: got %h want 0", out_keep); end
    n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL fill_data: got %h want 0", out_data); end
    wait_valid(12, "b2b_word");
    n_checks++; if (out_data !== 32'h88776655) begin n_fail++; $display("FAIL b2b_data: got %h want 88776655", out_data); end
    n_checks++; if (out_keep !== 4'hF) begin n_fail++; $display("FAIL b2b_keep: got %h want f", out_keep); end
    accept_word();
  endtask

  task automatic test_timeout();
    do_reset(2, 64'hBBAA);
    for (int c = 0; c < 19; c++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL tmo_early_valid: cycle %0d got %b want 0", c, out_valid); end
    end
    wait_valid(10, "tmo_valid");
    n_checks++; if (out_data !== 32'h0000BBAA) begin n_fail++; $display("FAIL tmo_data: got %h want 0000bbaa", out_data); end
    n_checks++; if (out_keep !== 4'b0011) begin n_fail++; $display("FAIL tmo_keep: got %b want 0011", out_keep); end
    n_checks++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL tmo_rd_en: got %b want 0", fifo_rd_en); end
    accept_word();
  endtask

  task automatic test_flush();
    do_reset(2, 64'h6B5A);
    @(posedge clk); #1;
    @(posedge clk); #1; flush = 1'b1;
    @(negedge clk);
    n_checks++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL flush_stop_rd: got %b want 0", fifo_rd_en); end
    @(posedge clk); #1; flush = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_c3_valid: got %b want 0", out_valid); end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_valid: got %b want 1", out_valid); end
    n_checks++; if (out_data !== 32'h00006B5A) begin n_fail++; $display("FAIL flush_data: got %h want 00006b5a", out_data); end
    n_checks++; if (out_keep !== 4'b0011) begin n_fail++; $display("FAIL flush_keep: got %b want 0011", out_keep); end
  endtask

  task automatic test_reset_mid();
    // Flush word is still held (out_ready low): reset it away.
    @(posedge clk); #1; reset = 1'b1;
    @(negedge clk);
    n_checks++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL rsthold_rd_en: got %b want 0", fifo_rd_en); end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rsthold_valid: got %b want 0", out_valid); end
    n_checks++; if (out_keep !== 4'h0) begin n_fail++; $display("FAIL rsthold_keep: got %h want 0", out_keep); end
    // Three bytes buffered, then reset.
    do_reset(3, 64'h030201);
    repeat (4) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b want 0", out_valid); end
    n_checks++; if (out_keep !== 4'h0) begin n_fail++; $display("FAIL rstmid_keep: got %h want 0", out_keep); end
    n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL rstmid_data: got %h want 0", out_data); end
    fifo_q.delete();
    fifo_q.push_back(8'hC1); fifo_q.push_back(8'hC2);
    fifo_q.push_back(8'hC3); fifo_q.push_back(8'hC4);
    @(posedge clk); #1; reset = 1'b0;
    wait_valid(10, "rstmid_next");
    n_checks++; if (out_data !== 32'hC4C3C2C1) begin n_fail++; $display("FAIL rstmid_next_data: got %h want c4c3c2c1", out_data); end
    n_checks++; if (out_keep !== 4'hF) begin n_fail++; $display("FAIL rstmid_next_keep: got %h want f", out_keep); end
    accept_word();
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_hold_stall();
    test_timeout();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
